// File: rtl/uart_rx_cfg.sv
// Runtime-configurable UART receiver.
// It has a 2-flop synchroniser and 3-sample majority voting. Frames are
// delivered through a valid/ready holding register. The block also flags
// overrun and line break.
module uart_rx_cfg #(
  parameter int MAX_DATA_BITS = 9,
  parameter int OVS_FACTOR    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     tick_ovs,
  input  logic                     rx_pin,
  input  logic [3:0]               cfg_data_bits,
  input  logic [2:0]               cfg_parity,
  input  logic                     cfg_stop2,
  input  logic                     rx_ready,
  output logic [MAX_DATA_BITS-1:0] rx_data,
  output logic                     rx_valid,
  output logic                     parity_err,
  output logic                     frame_err,
  output logic                     break_det,
  output logic                     overrun
);

  localparam int CW  = $clog2(OVS_FACTOR);
  localparam int IW  = $clog2(MAX_DATA_BITS);
  localparam int MID = OVS_FACTOR / 2;

  localparam logic [CW-1:0] C_MIDM = CW'(MID - 1);
  localparam logic [CW-1:0] C_MID  = CW'(MID);
  localparam logic [CW-1:0] C_MIDP = CW'(MID + 1);
  localparam logic [CW-1:0] C_LAST = CW'(OVS_FACTOR - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP1  = 3'd4;
  localparam logic [2:0] S_STOP2  = 3'd5;

  // synchroniser and edge-detect flops
  logic r_sync1, r_rx_s, r_rx_s_d;

  // frame engine state
  logic [2:0]               r_state;
  logic [CW-1:0]            r_os;
  logic [IW-1:0]            r_idx;
  logic [IW-1:0]            r_nlast;
  logic [2:0]               r_par;
  logic                     r_stop2;
  logic [MAX_DATA_BITS-1:0] r_word;
  logic                     r_s0, r_s1;
  logic                     r_pe, r_fe;
  logic                     r_allz;     // every vote so far was 0
  logic                     r_brkc;     // break candidate held for STOP2
  logic                     r_brk_wait; // line must return high before re-arming

  // output holding register
  logic [MAX_DATA_BITS-1:0] r_rx_data;
  logic                     r_rx_valid, r_par_err, r_frm_err, r_brk_det, r_ovr;

  logic [3:0]    w_nbits;
  logic [IW-1:0] w_nlast;
  logic [2:0]    w_par_mode;
  logic          w_vote, w_pexp, w_vtick, w_btick;
  logic          w_done, w_done_ferr, w_done_brk;

  // Clamp the data-bit count and fold unused parity codes to "none".
  always_comb begin
    w_nbits = cfg_data_bits;
    if (cfg_data_bits < 4'd5)
      w_nbits = 4'd5;
    else if (cfg_data_bits > 4'(MAX_DATA_BITS))
      w_nbits = 4'(MAX_DATA_BITS);
    w_nlast    = IW'(w_nbits - 4'd1);
    w_par_mode = (cfg_parity > 3'd4) ? 3'd0 : cfg_parity;
  end

  // Majority vote, expected parity and frame-completion decode.
  always_comb begin
    w_vote  = (r_s0 & r_s1) | (r_s0 & r_rx_s) | (r_s1 & r_rx_s);
    w_vtick = tick_ovs && (r_os == C_MIDP);
    w_btick = tick_ovs && (r_os == C_LAST);
    case (r_par)
      3'd1:    w_pexp = ~^r_word;
      3'd2:    w_pexp = ^r_word;
      3'd3:    w_pexp = 1'b1;
      default: w_pexp = 1'b0;
    endcase
    // The last stop bit finishes at its vote tick, which leaves slack for the next start edge.
    w_done      = w_vtick && (((r_state == S_STOP1) && !r_stop2) || (r_state == S_STOP2));
    w_done_ferr = r_fe | ~w_vote;
    w_done_brk  = (r_state == S_STOP1) ? (r_allz & ~w_vote) : r_brkc;
  end

  // Bring the async pin into the clock domain and keep one extra flop for the edge detector.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1  <= 1'b1;
      r_rx_s   <= 1'b1;
      r_rx_s_d <= 1'b1;
    end else begin
      r_sync1  <= rx_pin;
      r_rx_s   <= r_sync1;
      r_rx_s_d <= r_rx_s;
    end
  end

  // Frame state machine, advanced only on oversampling ticks once a start edge is seen.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_os       <= '0;
      r_idx      <= '0;
      r_nlast    <= '0;
      r_par      <= 3'd0;
      r_stop2    <= 1'b0;
      r_word     <= '0;
      r_s0       <= 1'b1;
      r_s1       <= 1'b1;
      r_pe       <= 1'b0;
      r_fe       <= 1'b0;
      r_allz     <= 1'b0;
      r_brkc     <= 1'b0;
      r_brk_wait <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (r_brk_wait) begin
        if (r_rx_s) r_brk_wait <= 1'b0;
      end else if (r_rx_s_d && !r_rx_s) begin
        r_state <= S_START;
        r_os    <= '0;
        r_nlast <= w_nlast;
        r_par   <= w_par_mode;
        r_stop2 <= cfg_stop2;
        r_word  <= '0;
        r_pe    <= 1'b0;
        r_fe    <= 1'b0;
        r_allz  <= 1'b1;
        r_brkc  <= 1'b0;
      end
    end else if (tick_ovs) begin
      r_os <= (r_os == C_LAST) ? '0 : r_os + CW'(1);
      if (r_os == C_MIDM) r_s0 <= r_rx_s;
      if (r_os == C_MID)  r_s1 <= r_rx_s;
      case (r_state)
        S_START: begin
          if (w_vtick && w_vote) r_state <= S_IDLE;
          else if (w_btick) begin
            r_state <= S_DATA;
            r_idx   <= '0;
          end
        end
        S_DATA: begin
          if (w_vtick) begin
            r_word[r_idx] <= w_vote;
            if (w_vote) r_allz <= 1'b0;
          end
          if (w_btick) begin
            if (r_idx == r_nlast) r_state <= (r_par != 3'd0) ? S_PARITY : S_STOP1;
            else r_idx <= r_idx + IW'(1);
          end
        end
        S_PARITY: begin
          if (w_vtick) begin
            r_pe <= (w_vote != w_pexp);
            if (w_vote) r_allz <= 1'b0;
          end
          if (w_btick) r_state <= S_STOP1;
        end
        S_STOP1: begin
          if (w_vtick) begin
            r_fe   <= w_done_ferr;
            r_brkc <= r_allz & ~w_vote;
            if (!r_stop2) begin
              r_state    <= S_IDLE;
              r_brk_wait <= w_done_brk;
            end
          end else if (w_btick) begin
            r_state <= S_STOP2;
          end
        end
        S_STOP2: begin
          if (w_vtick) begin
            r_state    <= S_IDLE;
            r_brk_wait <= r_brkc;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Output register: load completed frames, run the handshake, and pulse break/overrun.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_par_err  <= 1'b0;
      r_frm_err  <= 1'b0;
      r_brk_det  <= 1'b0;
      r_ovr      <= 1'b0;
    end else begin
      r_brk_det <= 1'b0;
      r_ovr     <= 1'b0;
      if (r_rx_valid && rx_ready) r_rx_valid <= 1'b0;
      if (w_done) begin
        if (w_done_brk) begin
          r_brk_det <= 1'b1;
        end else if (!r_rx_valid || rx_ready) begin
          r_rx_data  <= r_word;
          r_par_err  <= r_pe;
          r_frm_err  <= w_done_ferr;
          r_rx_valid <= 1'b1;
        end else begin
          r_ovr <= 1'b1;
        end
      end
    end
  end

  assign rx_data    = r_rx_data;
  assign rx_valid   = r_rx_valid;
  assign parity_err = r_par_err;
  assign frame_err  = r_frm_err;
  assign break_det  = r_brk_det;
  assign overrun    = r_ovr;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: directed frames plus randomised traffic, checked
// against a frame-level model.
module tb_uart_rx_cfg;
  localparam int OVS = 16;

  logic       clk = 1'b0, reset = 1'b1, tick_ovs = 1'b0, rx_pin = 1'b1;
  logic [3:0] cfg_data_bits = 4'd8;
  logic [2:0] cfg_parity = 3'd0;
  logic       cfg_stop2 = 1'b0, rx_ready = 1'b1;
  logic [8:0] rx_data;
  logic       rx_valid, parity_err, frame_err, break_det, overrun;

  int errors = 0, checks = 0;
  int brk_seen = 0, brk_hi = 0, ovr_seen = 0, ovr_hi = 0, exp_brk = 0, exp_ovr = 0;
  logic [10:0] expq[$];
  logic [10:0] e;
  logic        prev_brk = 0, prev_ovr = 0, prev_valid = 0, prev_ready = 0;
  logic [8:0]  prev_data = '0;
  int          tcnt = 0;

  uart_rx_cfg #(.MAX_DATA_BITS(9), .OVS_FACTOR(OVS)) dut (
    .clk(clk), .reset(reset), .tick_ovs(tick_ovs), .rx_pin(rx_pin),
    .cfg_data_bits(cfg_data_bits), .cfg_parity(cfg_parity), .cfg_stop2(cfg_stop2),
    .rx_ready(rx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
    .parity_err(parity_err), .frame_err(frame_err), .break_det(break_det), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // oversampling strobe: one cycle in four
  always @(negedge clk) begin
    tcnt = (tcnt + 1) % 4;
    tick_ovs = (tcnt == 0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // consumer side: score accepted frames and count pulses
  always @(negedge clk) begin
    if (!reset) begin
      if (rx_valid && prev_valid && !prev_ready) chk("hold_data", rx_data, prev_data);
      if (rx_valid && rx_ready) begin
        chk("frame_expected", expq.size() > 0, 1);
        if (expq.size() > 0) begin
          e = expq.pop_front();
          chk("rx_data", rx_data, e[10:2]);
          chk("parity_err", parity_err, e[1]);
          chk("frame_err", frame_err, e[0]);
        end
      end
      if (break_det) begin brk_hi++; if (!prev_brk) brk_seen++; end
      if (overrun)   begin ovr_hi++; if (!prev_ovr) ovr_seen++; end
      prev_brk   = break_det;
      prev_ovr   = overrun;
      prev_valid = rx_valid;
      prev_ready = rx_ready;
      prev_data  = rx_data;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  task automatic wait_tick();
    do @(posedge clk); while (tick_ovs !== 1'b1);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    rx_pin = b;
    repeat (OVS) wait_tick();
  endtask

  task automatic idle_ticks(input int n);
    rx_pin = 1'b1;
    repeat (n) wait_tick();
  endtask

  // Send one frame built from raw config values; the model derives what the receiver must report.
  task automatic send_frame(input logic [8:0] d, input int n, input int par, input bit s2,
                            input bit pinv, input bit st1, input bit st2,
                            input bit push, input bit scramble);
    int ne, ones;
    bit pe, pexp, pbit, perr, ferr, brk;
    logic [8:0] dm;
    ne   = (n < 5) ? 5 : ((n > 9) ? 9 : n);
    pe   = (par >= 1 && par <= 4);
    dm   = d & 9'((1 << ne) - 1);
    ones = $countones(dm);
    case (par)
      1: pexp = (ones % 2 == 0);
      2: pexp = (ones % 2 == 1);
      3: pexp = 1'b1;
      default: pexp = 1'b0;
    endcase
    pbit = pexp ^ pinv;
    perr = pe && pinv;
    ferr = !st1 || (s2 && !st2);
    brk  = (dm == 0) && (!pe || !pbit) && !st1;
    if (brk) exp_brk++;
    else if (push) expq.push_back({dm, perr, ferr});
    cfg_data_bits = 4'(n);
    cfg_parity    = 3'(par);
    cfg_stop2     = s2;
    drive_bit(1'b0);
    if (scramble) begin
      cfg_data_bits = 4'($urandom);
      cfg_parity    = 3'($urandom);
      cfg_stop2     = 1'($urandom);
    end
    for (int i = 0; i < ne; i++) drive_bit(d[i]);
    if (pe) drive_bit(pbit);
    drive_bit(st1);
    if (s2) drive_bit(st2);
    rx_pin = 1'b1;
  endtask

  initial begin
    int n, par;
    bit s2;
    logic [8:0] d;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", rx_valid, 0);
    chk("rst_data", rx_data, 0);
    chk("rst_perr", parity_err, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_brk", break_det, 0);
    chk("rst_ovr", overrun, 0);
    reset = 1'b0;
    idle_ticks(2 * OVS);

    // 8N1 0xA5
    send_frame(9'h0A5, 8, 0, 0, 0, 1, 1, 1, 0); idle_ticks(OVS);
    // 7E1 0x41, wrong then right parity
    send_frame(9'h041, 7, 2, 0, 1, 1, 1, 1, 0); idle_ticks(OVS);
    send_frame(9'h041, 7, 2, 0, 0, 1, 1, 1, 0); idle_ticks(OVS);
    // 9-bit mark parity, two stop bits, second stop low
    send_frame(9'h1FF, 9, 3, 1, 0, 1, 0, 1, 0); idle_ticks(OVS);
    chk("after_directed_q", expq.size(), 0);

    // glitch start bit
    rx_pin = 1'b0;
    repeat (4) wait_tick();
    idle_ticks(3 * OVS);
    chk("glitch_no_valid", rx_valid, 0);
    send_frame(9'h03C, 8, 0, 0, 0, 1, 1, 1, 0); idle_ticks(OVS);
    chk("glitch_q", expq.size(), 0);

    // overrun with consumer stalled
    rx_ready = 1'b0;
    send_frame(9'h011, 8, 0, 0, 0, 1, 1, 1, 0); idle_ticks(OVS);
    send_frame(9'h022, 8, 0, 0, 0, 1, 1, 0, 0); idle_ticks(OVS);
    exp_ovr++;
    chk("ovr_count", ovr_seen, exp_ovr);
    chk("ovr_hold_data", rx_data, 9'h011);
    chk("ovr_hold_valid", rx_valid, 1);
    rx_ready = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    chk("valid_fall", rx_valid, 0);

    // break: line low for two frame times
    cfg_data_bits = 4'd8; cfg_parity = 3'd0; cfg_stop2 = 1'b0;
    rx_pin = 1'b0;
    repeat (20 * OVS) wait_tick();
    idle_ticks(2 * OVS);
    exp_brk++;
    chk("brk_count", brk_seen, exp_brk);
    chk("brk_no_valid", rx_valid, 0);
    send_frame(9'h055, 8, 0, 0, 0, 1, 1, 1, 0); idle_ticks(OVS);
    chk("brk_q", expq.size(), 0);

    // reset mid-DATA with a frame held
    rx_ready = 1'b0;
    send_frame(9'h033, 8, 0, 0, 0, 1, 1, 1, 0); idle_ticks(OVS);
    chk("held_before_rst", rx_valid, 1);
    drive_bit(1'b0); drive_bit(1'b1); drive_bit(1'b0); drive_bit(1'b1);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("midrst_valid", rx_valid, 0);
    chk("midrst_data", rx_data, 0);
    chk("midrst_perr", parity_err, 0);
    chk("midrst_ferr", frame_err, 0);
    rx_pin = 1'b1;
    expq.delete();
    prev_valid = 1'b0;
    reset = 1'b0;
    rx_ready = 1'b1;
    idle_ticks(2 * OVS);
    send_frame(9'h05A, 8, 1, 0, 0, 1, 1, 1, 0); idle_ticks(OVS);
    chk("postrst_q", expq.size(), 0);

    // randomised traffic with config scrambled mid-frame
    for (int k = 0; k < 20; k++) begin
      n   = $urandom_range(0, 15);
      par = $urandom_range(0, 7);
      s2  = 1'($urandom_range(0, 1));
      d   = 9'($urandom);
      if ($urandom_range(0, 5) == 0) d = '0;
      send_frame(d, n, par, s2, ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) != 0), 1, 1);
      idle_ticks($urandom_range(2, 20));
    end

    idle_ticks(OVS);
    chk("final_q", expq.size(), 0);
    chk("final_brk", brk_seen, exp_brk);
    chk("final_ovr", ovr_seen, exp_ovr);
    chk("brk_width", brk_hi, brk_seen);
    chk("ovr_width", ovr_hi, ovr_seen);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
